// File: rtl/irq_ctrl_if.sv
// -----------------------------------------------------------------------------
// irq_ctrl_if -- IO bus between the j1 core and a memory-mapped peripheral.
//
// Signals:
//   io_rd    : read strobe, single cycle
//   io_wr    : write strobe, single cycle
//   io_addr  : 16-bit IO address
//   io_dout  : 16-bit write data from the core
//   io_rdata : 16-bit read data from the peripheral (zero when not selected)
//
// Modports:
//   master : the core side (drives strobes/address/data, receives rdata)
//   slave  : the peripheral side
// -----------------------------------------------------------------------------
interface irq_ctrl_if;
  logic        io_rd;
  logic        io_wr;
  logic [15:0] io_addr;
  logic [15:0] io_dout;
  logic [15:0] io_rdata;

  modport master (
    output io_rd, io_wr, io_addr, io_dout,
    input  io_rdata
  );

  modport slave (
    input  io_rd, io_wr, io_addr, io_dout,
    output io_rdata
  );
endinterface

// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl -- memory-mapped interrupt controller for the j1 core.
//
// Synchronizes 8 asynchronous sources, latches rising edges (edge mode) or
// follows levels (level mode) per source, masks them, and drives a registered
// one-hot request for the highest-priority pending source (bit 7 highest).
//
// Ports:
//   clk      : system clock, rising edge
//   reset    : synchronous, active-high reset
//   irq_src  : raw asynchronous interrupt sources, active high
//   io       : IO bus slave (io_rd, io_wr, io_addr, io_dout -> io_rdata)
//   int_rqst : registered one-hot request to the core
//
// Register map (word offset io_addr[3:1], io_addr[0] ignored):
//   0 PEND   R: {8'h00, PEND}   W: write-1-to-clear edge-mode bits
//   1 MASK   R/W [7:0]
//   2 MODE   R/W [7:0]          1 = edge, 0 = level
//   3 SWTRIG R: 0               W: write-1-to-set edge-mode bits
//   4 ACTIVE R: {12'h000, valid, idx[2:0]}
//   5..7     R: 0               W: ignored
// -----------------------------------------------------------------------------
module irq_ctrl #(
  parameter logic [15:0] BASE     = 16'h0040,
  parameter logic [7:0]  MODE_RST = 8'hFF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   irq_src,
  irq_ctrl_if.slave    io,
  output logic [7:0]   int_rqst
);

  typedef enum logic [2:0] {
    OFF_PEND   = 3'd0,
    OFF_MASK   = 3'd1,
    OFF_MODE   = 3'd2,
    OFF_SWTRIG = 3'd3,
    OFF_ACTIVE = 3'd4
  } reg_off_e;

  logic [7:0] sync1_q, sync1_d;
  logic [7:0] sync2_q, sync2_d;
  logic [7:0] prev_q,  prev_d;
  logic [7:0] pend_q,  pend_d;
  logic [7:0] mask_q,  mask_d;
  logic [7:0] mode_q,  mode_d;
  logic [7:0] int_rqst_q, int_rqst_d;

  logic       sel;
  logic [2:0] off;
  logic       wr_en;
  logic [7:0] rise;
  logic [7:0] clr;
  logic [7:0] swset;
  logic [7:0] req;
  logic       act_valid;
  logic [2:0] act_idx;

  // Address bit 0 and the upper write-data byte carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{io.io_addr[0], io.io_dout[15:8]};

  assign sel   = (io.io_addr[15:4] == BASE[15:4]);
  assign off   = io.io_addr[3:1];
  assign wr_en = io.io_wr & sel;

  // A source already high when reset releases has prev=0, so it shows up
  // as a rising edge.
  assign rise  = sync2_q & ~prev_q;
  assign clr   = (wr_en && off == OFF_PEND)   ? io.io_dout[7:0] : 8'h00;
  assign swset = (wr_en && off == OFF_SWTRIG) ? io.io_dout[7:0] : 8'h00;
  assign req   = pend_q & mask_q;

  // Next-state for all registers.
  // NOTE: every always_comb output gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    sync1_d = irq_src;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    mask_d  = mask_q;
    mode_d  = mode_q;

    if (wr_en && off == OFF_MASK) mask_d = io.io_dout[7:0];
    if (wr_en && off == OFF_MODE) mode_d = io.io_dout[7:0];

    // The current MODE selects the rule; a 0->1 switch therefore keeps the
    // last level-tracked value, a 1->0 switch follows the level next cycle.
    // Set terms are OR-ed after the clear so set wins over clear.
    for (int i = 0; i < 8; i++) begin
      if (mode_q[i]) pend_d[i] = rise[i] | swset[i] | (pend_q[i] & ~clr[i]);
      else           pend_d[i] = sync2_q[i];
    end

    // Ascending scan: the last hit is the highest set bit.
    int_rqst_d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (req[i]) int_rqst_d = 8'(1 << i);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= 8'h00;
      sync2_q    <= 8'h00;
      prev_q     <= 8'h00;
      pend_q     <= 8'h00;
      mask_q     <= 8'h00;
      mode_q     <= MODE_RST;
      int_rqst_q <= 8'h00;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      pend_q     <= pend_d;
      mask_q     <= mask_d;
      mode_q     <= mode_d;
      int_rqst_q <= int_rqst_d;
    end
  end

  assign int_rqst = int_rqst_q;

  // Encode the active request for the ACTIVE register.
  always_comb begin
    act_valid = |int_rqst_q;
    act_idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (int_rqst_q[i]) act_idx = 3'(i);
    end
  end

  // Read data is zero unless this block is read, so several peripherals can
  // be OR-combined onto one return bus.
  always_comb begin
    io.io_rdata = 16'h0000;
    if (io.io_rd && sel) begin
      case (off)
        OFF_PEND:   io.io_rdata = {8'h00, pend_q};
        OFF_MASK:   io.io_rdata = {8'h00, mask_q};
        OFF_MODE:   io.io_rdata = {8'h00, mode_q};
        OFF_ACTIVE: io.io_rdata = {12'h000, act_valid, act_idx};
        default:    io.io_rdata = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_ctrl -- self-checking bench for irq_ctrl.
// A behavioural model tracks source history, registers and the request;
// a negedge process compares int_rqst and io_rdata every cycle. Directed
// scenarios add literal expectations, followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_irq_ctrl;
  localparam logic [15:0] BASE     = 16'h0040;
  localparam logic [7:0]  MODE_RST = 8'hFF;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irq_src;
  logic [7:0] int_rqst;

  irq_ctrl_if bus ();

  irq_ctrl #(.BASE(BASE), .MODE_RST(MODE_RST)) dut (
    .clk      (clk),
    .reset    (reset),
    .irq_src  (irq_src),
    .io       (bus.slave),
    .int_rqst (int_rqst)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // hist[k] = irq_src value sampled k+1 edges ago. A source change becomes a
  // level seen by PEND two edges later; a rise is "seen now, not one earlier".
  logic [7:0] hist [3];
  logic [7:0] m_pend, m_mask, m_mode, m_rq;

  function automatic logic [7:0] top_one(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) if (v[i]) return 8'(1 << i);
    return 8'h00;
  endfunction

  function automatic logic [15:0] m_rdata();
    logic [3:0] enc;
    if (!(bus.io_rd && bus.io_addr[15:4] == BASE[15:4])) return 16'h0000;
    enc = 4'h0;
    for (int i = 0; i < 8; i++) if (m_rq[i]) enc = {1'b1, 3'(i)};
    case (bus.io_addr[3:1])
      3'd0: return {8'h00, m_pend};
      3'd1: return {8'h00, m_mask};
      3'd2: return {8'h00, m_mode};
      3'd4: return {12'h000, enc};
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) begin : model
    logic [7:0] lvl, rs, clr, set, np;
    if (reset) begin
      for (int k = 0; k < 3; k++) hist[k] <= 8'h00;
      m_pend <= 8'h00; m_mask <= 8'h00; m_mode <= MODE_RST; m_rq <= 8'h00;
    end else begin
      lvl = hist[1];
      rs  = hist[1] & ~hist[2];
      clr = 8'h00;
      set = 8'h00;
      if (bus.io_wr && bus.io_addr[15:4] == BASE[15:4]) begin
        case (bus.io_addr[3:1])
          3'd0: clr = bus.io_dout[7:0];
          3'd1: m_mask <= bus.io_dout[7:0];
          3'd2: m_mode <= bus.io_dout[7:0];
          3'd3: set = bus.io_dout[7:0];
          default: ;
        endcase
      end
      for (int i = 0; i < 8; i++)
        np[i] = m_mode[i] ? (rs[i] | set[i] | (m_pend[i] & ~clr[i])) : lvl[i];
      m_rq    <= top_one(m_pend & m_mask);
      m_pend  <= np;
      hist[0] <= irq_src;
      hist[1] <= hist[0];
      hist[2] <= hist[1];
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("int_rqst_model", {8'h00, int_rqst}, {8'h00, m_rq});
      check("io_rdata_model", bus.io_rdata, m_rdata());
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [2:0] off, input logic [15:0] data);
    bus.io_wr = 1'b1; bus.io_addr = BASE | {12'h000, off, 1'b0}; bus.io_dout = data;
    cyc();
    bus.io_wr = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [2:0] off, input logic [15:0] exp);
    bus.io_rd = 1'b1; bus.io_addr = BASE | {12'h000, off, 1'b0};
    #1;
    check(name, bus.io_rdata, exp);
    bus.io_rd = 1'b0;
  endtask

  task automatic rq_chk(input string name, input logic [7:0] exp);
    check(name, {8'h00, int_rqst}, {8'h00, exp});
  endtask

  initial begin
    reset = 1'b1; irq_src = 8'h00;
    bus.io_rd = 1'b0; bus.io_wr = 1'b0; bus.io_addr = 16'h0000; bus.io_dout = 16'h0000;
    cyc(); cyc();
    reset = 1'b0;
    chk_en = 1'b1;

    // Reset state
    rq_chk("rst_rqst", 8'h00);
    check("rst_rdata_idle", bus.io_rdata, 16'h0000);
    rd_chk("rst_pend", 3'd0, 16'h0000);
    rd_chk("rst_mask", 3'd1, 16'h0000);
    rd_chk("rst_mode", 3'd2, 16'h00FF);
    rd_chk("rst_swtrig", 3'd3, 16'h0000);
    rd_chk("rst_active", 3'd4, 16'h0000);

    // Single source, 4-clock latency, W1C
    wr(3'd1, 16'h0008);
    irq_src = 8'h08; cyc(); irq_src = 8'h00;      // edge 1
    rq_chk("lat_e1", 8'h00); cyc();
    rq_chk("lat_e2", 8'h00); cyc();
    rq_chk("lat_e3", 8'h00); cyc();
    rq_chk("lat_e4", 8'h08);
    rd_chk("active_3", 3'd4, 16'h000B);
    wr(3'd0, 16'h0008);
    rq_chk("w1c_same", 8'h08); cyc();
    rq_chk("w1c_next", 8'h00);

    // Priority and preemption
    wr(3'd1, 16'h00FF);
    irq_src = 8'h62; cyc(); irq_src = 8'h00;
    cyc(); cyc(); cyc();
    rq_chk("prio_6", 8'h40);
    wr(3'd0, 16'h0040); cyc();
    rq_chk("prio_5", 8'h20);
    wr(3'd0, 16'h0020); cyc();
    rq_chk("prio_1", 8'h02);
    wr(3'd0, 16'h0002); cyc();
    rq_chk("prio_none", 8'h00);

    // Set wins over clear
    wr(3'd3, 16'h0004);
    irq_src = 8'h04; cyc(); cyc();                 // edges 1,2
    wr(3'd0, 16'h0004);                            // edge 3: rise + W1C
    rd_chk("set_wins", 3'd0, 16'h0004);
    irq_src = 8'h00;
    wr(3'd0, 16'h0004);
    rq_chk("pre_sw", 8'h04);
    wr(3'd3, 16'h0080);
    rq_chk("sw_e0", 8'h00); cyc();
    rq_chk("sw_e1", 8'h80);
    wr(3'd0, 16'h0080); cyc();

    // Level mode
    wr(3'd2, 16'h0000);
    wr(3'd1, 16'h0001);
    irq_src = 8'h01; cyc(); cyc(); cyc(); cyc();
    rq_chk("lvl_on", 8'h01);
    for (int k = 0; k < 3; k++) begin
      wr(3'd0, 16'h0001);
      rq_chk("lvl_w1c", 8'h01);
    end
    irq_src = 8'h00; cyc(); cyc(); cyc();
    rq_chk("lvl_e3", 8'h01); cyc();
    rq_chk("lvl_off", 8'h00);

    // Reset mid-pending with a simultaneous MASK write
    wr(3'd2, 16'h00FF);
    wr(3'd1, 16'h00FF);
    wr(3'd3, 16'h0010); cyc();
    rq_chk("pre_rst", 8'h10);
    reset = 1'b1;
    bus.io_wr = 1'b1; bus.io_addr = BASE | 16'h0002; bus.io_dout = 16'h0055;
    cyc();
    reset = 1'b0; bus.io_wr = 1'b0;
    rq_chk("rst2_rqst", 8'h00);
    rd_chk("rst2_mask", 3'd1, 16'h0000);
    rd_chk("rst2_mode", 3'd2, 16'h00FF);
    rd_chk("rst2_pend", 3'd0, 16'h0000);

    // Randomized phase, checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] r;
      r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) irq_src = 8'($urandom);
      reset     = ($urandom_range(0, 299) == 0);
      bus.io_wr = (r < 4);
      bus.io_rd = (r >= 4 && r < 10);
      bus.io_addr = ($urandom_range(0, 7) == 0) ? 16'($urandom)
                  : (BASE | {12'h000, 3'($urandom_range(0, 7)), 1'($urandom)});
      bus.io_dout = 16'($urandom);
      #1;
      check("rand_rdata", bus.io_rdata, m_rdata());
      cyc();
    end
    reset = 1'b0; bus.io_wr = 1'b0; bus.io_rd = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Memory-mapped interrupt controller in front of the j1 core's 8-line `int_rqst` input.
- Synchronizes 8 asynchronous sources and latches edge events or follows levels per source.
- Applies a software enable mask and drives a registered one-hot request, highest pending source only.
- Firmware accesses it on the IO bus (`io_rd`/`io_wr`, 16-bit address/data) to clear, mask, trigger and identify interrupts.

Parameters:
- BASE, 16'h0040: IO base address; block decodes `io_addr[15:4] == BASE[15:4]`.
- MODE_RST, 8'hFF: reset value of MODE register (1 = edge, 0 = level).

Ports:
- clk, input, 1: system clock, all logic on rising edge.
- reset, input, 1: synchronous, active-high reset.
- irq_src, input, 8: raw interrupt sources, asynchronous, active-high; bit 7 is highest priority.
- io_rd, input, 1: IO read strobe, single cycle.
- io_wr, input, 1: IO write strobe, single cycle.
- io_addr, input, 16: IO address.
- io_dout, input, 16: write data from the core.
- io_rdata, output, 16: read data, combinational.
- int_rqst, output, 8: one-hot request to the core, registered.

Behaviour:
- Reset (clk edge with reset=1):
  - sync1, sync2, prev, PEND, MASK, int_rqst <= 0; MODE <= MODE_RST.
  - reset overrides any simultaneous `io_wr`.
  - reset mid-pending drops all requests.
- Synchronizer: sync1 <= irq_src; sync2 <= sync1; prev <= sync2.
  - rise = sync2 & ~prev.
  - A source already high when reset releases is seen as a rising edge.
- Register map, word offset off = io_addr[3:1], io_addr[0] ignored:
  - off 0 PEND: R = {8'h00, PEND}; W = write-1-to-clear on edge-mode bits.
  - off 1 MASK: R/W bits [7:0]; upper bits read 0, ignored on write.
  - off 2 MODE: R/W bits [7:0].
  - off 3 SWTRIG: W = write-1-to-set PEND on edge-mode bits; R = 0.
  - off 4 ACTIVE: R = {12'h000, valid, idx[2:0]}, where valid = |int_rqst and idx = encoded bit of int_rqst (0 when invalid).
  - off 5..7: R = 0, W ignored.
- Select: sel = (io_addr[15:4] == BASE[15:4]).
  - io_rdata = register value when io_rd & sel, else 16'h0000, so it can be OR-combined with other peripherals.
  - Reads have no side effects.
- PEND update per bit i, each cycle:
  - Level mode (MODE[i]=0): PEND[i] <= sync2[i]; W1C and SWTRIG have no effect.
  - Edge mode (MODE[i]=1): PEND[i] <= rise[i] | swset[i] | (PEND[i] & ~clr[i]).
  - Set wins over clear in the same cycle.
  - Switching MODE 0->1 keeps the current PEND value; 1->0 makes PEND follow the level from the next cycle.
- Request:
  - req = PEND & MASK.
  - int_rqst <= one-hot of the highest set bit of req, 0 if none.
  - At most one bit of int_rqst is set at any time.
- Latency:
  - Source rises before edge 1 -> PEND set after edge 3 -> int_rqst after edge 4 (4 clocks).
  - MASK/SWTRIG/W1C write at edge N -> int_rqst reflects it after edge N+1.
- Lower-priority sources are preempted, not lost: they stay pending and appear once higher ones clear.
- The core disables its own global enable on entry; the ISR must W1C its PEND bit before re-enabling (edge mode) or quiet the source (level mode).
- Glitches shorter than one clock may be missed; this is a documented limitation, not an error.

Test Plan:
- Reset, then read all offsets -> PEND=0, MASK=0, MODE=16'h00FF, ACTIVE=0, int_rqst=0, io_rdata=0 with io_rd low.
- MASK=8'h08, pulse irq_src[3] for 1 clock -> int_rqst=8'h08 exactly 4 clocks later; ACTIVE reads 16'h000B; W1C PEND with 16'h0008 -> int_rqst=0 one clock after the write.
- MASK=8'hFF, raise src 1, 5, 6 simultaneously -> int_rqst=8'h40; clear bit 6 -> 8'h20; clear bit 5 -> 8'h02.
- Edge on src 2 in the same cycle as a W1C of bit 2 -> PEND[2] stays 1; SWTRIG write 16'h0080 with MASK[7]=1 -> int_rqst=8'h80 after 2 clocks.
- MODE=8'h00, MASK=8'h01, hold src 0 high -> int_rqst=8'h01 persists through W1C writes; drop src 0 -> int_rqst=0 after 4 clocks.
- Assert reset while int_rqst=8'h10 and io_wr targets MASK -> next cycle all registers at reset values, write discarded.
